// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN datapath blocks around the fully-connected
// layer: feeder FSM state encoding, default geometry, and the helper that
// locates one element inside a flattened feature vector.
// -----------------------------------------------------------------------------
package cnn_pkg;

  // Default geometry of the FC input vector and the done-flag timeout.
  localparam int N_FEAT_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_CLEAR = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } fsm_state_e;

  // Low bit of element idx inside a flattened vector of w-bit elements.
  function automatic int unsigned elem_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fc_feeder_feat_buffer.sv
// -----------------------------------------------------------------------------
// feat_buffer
// N_FEAT x DATA_W register file filled in order through an internal write
// pointer. A clear zeroes every entry and rewinds the pointer; the whole file
// is presented as one flattened vector (element i at [i*DATA_W +: DATA_W]).
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr_i       zero all entries and rewind the pointer (wins over a write)
//   wr_en_i     store wr_data_i at the current pointer, then advance it
//   wr_data_i   word to store
//   wr_ptr_o    number of words stored since the last clear
//   vec_o       flattened contents of the register file
// -----------------------------------------------------------------------------
module feat_buffer
  import cnn_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = $clog2(N_FEAT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic [PTR_W-1:0]           wr_ptr_o,
  output logic [N_FEAT*DATA_W-1:0]   vec_o
);

  logic [DATA_W-1:0] mem_q [N_FEAT];
  logic [PTR_W-1:0]  ptr_q;

  // Write pointer: rewinds on clear, saturates once every entry is written.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ptr_q <= {PTR_W{1'b0}};
    end else if (wr_en_i && (ptr_q != PTR_W'(N_FEAT))) begin
      ptr_q <= ptr_q + PTR_W'(1);
    end else begin
      ptr_q <= ptr_q;
    end
  end

  // Entry storage: clear zeroes everything, otherwise only the addressed entry loads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FEAT; i++) begin
      if (rst || clr_i) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end else if (wr_en_i && (ptr_q == PTR_W'(i))) begin
        mem_q[i] <= wr_data_i;
      end else begin
        mem_q[i] <= mem_q[i];
      end
    end
  end

  for (genvar g = 0; g < N_FEAT; g++) begin : g_vec
    assign vec_o[elem_lo(g, DATA_W) +: DATA_W] = mem_q[g];
  end

  assign wr_ptr_o = ptr_q;

endmodule

// File: rtl/fc_feeder.sv
// -----------------------------------------------------------------------------
// fc_feeder
// Upstream driver of the fully-connected layer. Gathers a serial frame of
// signed feature words, presents them as the FC layer's parallel input,
// issues one clear pulse followed by one compute pulse, waits (bounded) for
// the layer's done flag and hands the captured result downstream on a
// valid/ready handshake before accepting the next frame.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/last    serial feature stream, in_last ends a frame
//   in_ready              high while a frame is being collected
//   fc_vec                feature vector, element i at [i*DATA_W +: DATA_W]
//   fc_clr, fc_enable     one-cycle clear and compute pulses to the FC layer
//   fc_done, fc_result    sticky done flag and result of the FC layer
//   res_data/valid/err    captured result (err=1: timeout, data=0)
//   res_ready             downstream accepts the result
//   frame_err             one-cycle pulse: frame filled without in_last
// -----------------------------------------------------------------------------
module fc_feeder
  import cnn_pkg::*;
#(
  parameter int N_FEAT  = N_FEAT_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [N_FEAT*DATA_W-1:0]    fc_vec,
  output logic                        fc_clr,
  output logic                        fc_enable,
  input  logic                        fc_done,
  input  logic signed [DATA_W-1:0]    fc_result,
  output logic signed [DATA_W-1:0]    res_data,
  output logic                        res_valid,
  output logic                        res_err,
  input  logic                        res_ready,
  output logic                        frame_err
);

  localparam int PTR_W = $clog2(N_FEAT + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  fsm_state_e                state_q;
  logic                      in_ready_q;
  logic                      fc_clr_q;
  logic                      fc_enable_q;
  logic                      frame_err_q;
  logic                      res_valid_q;
  logic                      res_err_q;
  logic signed [DATA_W-1:0]  res_data_q;
  logic [TMO_W-1:0]          tmo_q;

  logic                      accept_s;
  logic                      last_slot_s;
  logic                      frame_end_s;
  logic                      buf_clr_s;
  logic [PTR_W-1:0]          wr_ptr_s;

  // Handshake and frame-boundary decode; the buffer is wiped when the result
  // leaves (FILL re-entry) or if the state register ever holds an illegal code.
  always_comb begin
    accept_s    = in_valid & in_ready_q;
    last_slot_s = (wr_ptr_s == PTR_W'(N_FEAT - 1));
    frame_end_s = accept_s & (in_last | last_slot_s);
    buf_clr_s   = 1'b0;
    case (state_q)
      S_OUT:   buf_clr_s = res_ready;
      S_FILL,
      S_CLEAR,
      S_FIRE,
      S_WAIT:  buf_clr_s = 1'b0;
      default: buf_clr_s = 1'b1;
    endcase
  end

  feat_buffer #(
    .N_FEAT (N_FEAT),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (buf_clr_s),
    .wr_en_i   (accept_s),
    .wr_data_i (in_data),
    .wr_ptr_o  (wr_ptr_s),
    .vec_o     (fc_vec)
  );

  // Frame sequencing FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      in_ready_q  <= 1'b1;
      fc_clr_q    <= 1'b0;
      fc_enable_q <= 1'b0;
      frame_err_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= {DATA_W{1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
    end else begin
      // Pulses are single-cycle unless a transition below re-asserts them.
      fc_clr_q    <= 1'b0;
      fc_enable_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (frame_end_s) begin
            state_q     <= S_CLEAR;
            in_ready_q  <= 1'b0;
            fc_clr_q    <= 1'b1;
            // Only a frame closed by the slot limit lacks in_last here.
            frame_err_q <= ~in_last;
          end
        end
        S_CLEAR: begin
          state_q     <= S_FIRE;
          fc_enable_q <= 1'b1;
        end
        S_FIRE: begin
          state_q <= S_WAIT;
          tmo_q   <= {TMO_W{1'b0}};
        end
        S_WAIT: begin
          // Done is tested first so it wins over a simultaneous expiry.
          if (fc_done) begin
            state_q     <= S_OUT;
            res_data_q  <= fc_result;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_q     <= S_OUT;
            res_data_q  <= {DATA_W{1'b0}};
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_OUT: begin
          if (res_ready) begin
            state_q     <= S_FILL;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= {DATA_W{1'b0}};
          end
        end
        default: begin
          state_q     <= S_FILL;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
          res_err_q   <= 1'b0;
          res_data_q  <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign fc_clr    = fc_clr_q;
  assign fc_enable = fc_enable_q;
  assign frame_err = frame_err_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_fc_feeder.sv
module tb_fc_feeder;

  localparam int N_FEAT  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic signed [DATA_W-1:0]  in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [N_FEAT*DATA_W-1:0]  fc_vec;
  logic                      fc_clr;
  logic                      fc_enable;
  logic                      fc_done;
  logic signed [DATA_W-1:0]  fc_result;
  logic signed [DATA_W-1:0]  res_data;
  logic                      res_valid;
  logic                      res_err;
  logic                      res_ready;
  logic                      frame_err;

  fc_feeder #(.N_FEAT(N_FEAT), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .fc_vec(fc_vec), .fc_clr(fc_clr), .fc_enable(fc_enable),
    .fc_done(fc_done), .fc_result(fc_result),
    .res_data(res_data), .res_valid(res_valid), .res_err(res_err), .res_ready(res_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // ---------------- FC layer model: all weights 1, done one cycle after compute
  logic signed [DATA_W-1:0] fc_acc  = '0;
  logic                     fc_pend = 1'b0;
  logic                     fc_dn   = 1'b0;
  bit                       fc_hang = 1'b0;
  int                       clr_cnt = 0;
  int                       en_cnt  = 0;

  function automatic logic signed [DATA_W-1:0] vec_sum(input logic [N_FEAT*DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < N_FEAT; i++) s = s + $signed(v[i*DATA_W +: DATA_W]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (fc_clr) begin
      fc_acc  <= '0;
      fc_pend <= 1'b0;
      fc_dn   <= 1'b0;
      clr_cnt <= clr_cnt + 1;
    end else begin
      if (fc_enable) begin
        fc_acc  <= fc_acc + vec_sum(fc_vec);
        fc_pend <= !fc_hang;
        en_cnt  <= en_cnt + 1;
      end
      fc_dn <= fc_dn | fc_pend;
    end
  end
  assign fc_done   = fc_dn;
  assign fc_result = fc_acc;

  // ---------------- Reference model: frames are split by in_last or N_FEAT words
  int                       n_chk  = 0;
  int                       n_fail = 0;
  int                       mdl_cnt = 0;
  logic signed [DATA_W-1:0] mdl_sum = '0;
  logic [DATA_W-1:0]        mdl_vec [N_FEAT];
  logic [DATA_W-1:0]        exp_vec [N_FEAT];
  bit                       exp_ferr;
  logic signed [DATA_W-1:0] exp_q [$];
  int                       c0, e0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic signed [DATA_W-1:0] d, input bit last);
    int k;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mdl_vec[mdl_cnt] = d;
    mdl_sum = mdl_sum + d;
    mdl_cnt++;
    if (last || mdl_cnt == N_FEAT) begin
      exp_ferr = !last;
      exp_vec  = mdl_vec;
      exp_q.push_back(mdl_sum);
      mdl_cnt = 0;
      mdl_sum = '0;
      for (int i = 0; i < N_FEAT; i++) mdl_vec[i] = '0;
    end
  endtask

  // Called right after the frame-closing word was accepted (edge T).
  task automatic check_launch();
    c0 = clr_cnt;
    e0 = en_cnt;
    chk("clr_pulse", fc_clr, 1);
    chk("enable_idle_in_clear", fc_enable, 0);
    chk("in_ready_low_clear", in_ready, 0);
    chk("frame_err", frame_err, exp_ferr);
    for (int i = 0; i < N_FEAT; i++)
      chk($sformatf("fc_vec[%0d]", i), fc_vec[i*DATA_W +: DATA_W], exp_vec[i]);
    tick();
    chk("enable_pulse", fc_enable, 1);
    chk("clr_drop", fc_clr, 0);
    chk("frame_err_drop", frame_err, 0);
    tick();
    chk("enable_drop", fc_enable, 0);
  endtask

  task automatic wait_result(input bit hang);
    int k;
    logic signed [DATA_W-1:0] e;
    k = 0;
    while (res_valid !== 1'b1 && k < 4*TIMEOUT) begin
      tick();
      k++;
    end
    e = exp_q.pop_front();
    if (hang) begin
      e = '0;
      chk("timeout_latency", k, TIMEOUT);
    end else begin
      chk("done_latency", k, 2);
    end
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, e);
    chk("res_err", res_err, hang);
  endtask

  task automatic drain(input int dly, input bit offer);
    logic signed [DATA_W-1:0] held;
    held = res_data;
    for (int j = 0; j < dly; j++) begin
      if (offer) begin
        in_valid = 1'b1;
        in_data  = 32'sd77;
      end
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("in_ready_rearm", in_ready, 1);
    chk("clr_once", clr_cnt, c0 + 1);
    chk("enable_once", en_cnt, e0 + 1);
    chk("buf0_zeroed", fc_vec[DATA_W-1:0], 0);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fc_clr", fc_clr, 0);
    chk("rst_fc_enable", fc_enable, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_fc_vec_zero", (fc_vec == '0), 1);
  endtask

  task automatic frame_1_to_9();
    for (int v = 1; v <= 9; v++) send_word(v, v == 9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit lastf, hang;
    for (int i = 0; i < N_FEAT; i++) mdl_vec[i] = '0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    chk_reset();
    rst = 1'b0;

    // Full frame 1..9, nominal latency and single pulses
    frame_1_to_9();
    check_launch();
    wait_result(1'b0);
    drain(0, 1'b0);

    // Short frame -3, 7, 2
    send_word(-3, 1'b0); send_word(7, 1'b0); send_word(2, 1'b1);
    check_launch();
    wait_result(1'b0);
    drain(1, 1'b0);

    // Overrun: 9 words without in_last, 10th word opens the next frame
    for (int v = 1; v <= 9; v++) send_word(v, 1'b0);
    check_launch();
    wait_result(1'b0);
    drain(0, 1'b0);
    send_word(10, 1'b1);
    check_launch();
    wait_result(1'b0);
    drain(0, 1'b0);

    // FC never done -> timeout, then a normal frame
    fc_hang = 1'b1;
    frame_1_to_9();
    check_launch();
    wait_result(1'b1);
    drain(0, 1'b0);
    fc_hang = 1'b0;
    send_word(5, 1'b0); send_word(5, 1'b1);
    check_launch();
    wait_result(1'b0);
    drain(0, 1'b0);

    // Back-pressure in OUT with words offered upstream
    for (int v = 1; v <= 4; v++) send_word(v * 11, v == 4);
    check_launch();
    wait_result(1'b0);
    drain(5, 1'b1);

    // Reset while waiting for done
    frame_1_to_9();
    check_launch();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset();
    void'(exp_q.pop_front());
    for (int j = 0; j < 6; j++) tick();
    chk("no_result_after_rst_wait", res_valid, 0);
    frame_1_to_9();
    check_launch();
    wait_result(1'b0);

    // Reset while the result is pending
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset();
    for (int j = 0; j < 4; j++) tick();
    chk("no_result_after_rst_out", res_valid, 0);
    frame_1_to_9();
    check_launch();
    wait_result(1'b0);
    drain(2, 1'b0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      n     = $urandom_range(1, N_FEAT);
      lastf = (n < N_FEAT) ? 1'b1 : 1'($urandom_range(0, 1));
      hang  = ($urandom_range(0, 7) == 0);
      fc_hang = hang;
      for (int w = 0; w < n; w++)
        send_word(int'($urandom_range(0, 4000)) - 2000, lastf && (w == n - 1));
      check_launch();
      wait_result(hang);
      drain($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      fc_hang = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_feeder.md
Name: fc_feeder

Overview:
- Upstream driver for the fully-connected layer.
- Collects a serial stream of signed feature words (pooling/flatten output) into an N_FEAT-entry buffer.
- Drives the FC layer's parallel input vector with a clear/enable sequence, waits for its done flag, and captures the result.
- Presents the captured result downstream on a valid/ready handshake, then re-arms for the next frame.

Parameters:
- N_FEAT, 9, number of feature words per frame (FC input width).
- DATA_W, 32, signed feature/result word width.
- TIMEOUT, 16, max WAIT cycles for fc_done before flagging an error (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  signed feature word.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final word of a frame; qualified by in_valid.
- in_ready  out  1  feeder accepts a word this cycle.
- fc_vec  out  N_FEAT*DATA_W  feature vector; element i at [i*DATA_W +: DATA_W].
- fc_clr  out  1  one-cycle clear pulse to the FC layer (drives its rst).
- fc_enable  out  1  one-cycle compute pulse to the FC layer.
- fc_done  in  1  FC layer done (level, sticky until fc_clr).
- fc_result  in  DATA_W  FC layer output, valid while fc_done=1.
- res_data  out  DATA_W  captured result.
- res_valid  out  1  res_data valid.
- res_err  out  1  qualifies res_data: 1 = timeout, res_data=0.
- res_ready  in  1  downstream accepts result.
- frame_err  out  1  one-cycle pulse: frame overran N_FEAT words without in_last.

Behaviour:
- Reset values: state=FILL, word count=0, buffer all zero. All outputs 0 except in_ready=1.
- Reset mid-frame discards the partial buffer and any pending result.

FSM states: FILL, CLEAR, FIRE, WAIT, OUT.
- FILL:
  - in_ready=1. A word is accepted when in_valid & in_ready; it is written to buf[count] and count increments.
  - Leave FILL after accepting a word with in_last=1 or with count==N_FEAT-1, whichever comes first.
  - Short frame (in_last before N_FEAT words): the remaining entries are zero. Buffer entries are zeroed on entry to FILL.
  - Word N_FEAT accepted with in_last=0: frame_err pulses for 1 cycle (the next cycle, together with CLEAR). The frame still proceeds. Upstream words after that belong to the next frame.
- CLEAR: in_ready=0, fc_clr=1 for exactly 1 cycle → FIRE.
- FIRE: fc_enable=1 for exactly 1 cycle. The FC layer accumulates every enabled cycle, so enable must never exceed 1 cycle/frame. → WAIT, with the timeout counter reset to 0.
- WAIT:
  - Sample fc_done each cycle.
  - On fc_done=1: register res_data=fc_result, res_err=0 → OUT.
  - If fc_done is never seen: after TIMEOUT WAIT cycles register res_data=0, res_err=1 → OUT.
  - fc_done=1 on the same cycle the counter expires: done wins (res_err=0).
- OUT:
  - res_valid=1; res_data/res_err held stable until res_ready=1.
  - On the handshake cycle: res_valid drops next cycle, → FILL, count=0.
  - in_ready stays 0 throughout OUT; there is no overlap of the next frame with the pending result.
- fc_vec is a registered copy of the buffer and is stable from CLEAR through OUT.
- Latency: last word accepted at edge T.
  - CLEAR at T+1, FIRE at T+2.
  - Nominal FC asserts done at T+3; WAIT captures it.
  - res_valid=1 from T+4.
- No arithmetic is performed in the feeder. Data is passed bit-exact, with signed DATA_W throughout.

Decomposition:
- Shared package `cnn_pkg`:
  - state enum (FILL/CLEAR/FIRE/WAIT/OUT);
  - N_FEAT/DATA_W defaults;
  - the fc_vec element index helper constant.
- Sub-module: `feat_buffer` (N_FEAT x DATA_W register file with write pointer, clear-all, and flattened read-out). The FSM, handshake, and timeout logic stay in fc_feeder.

Test Plan:
- Full frame 1..9 (in_last on the 9th word), FC model with all weights 1, done after 1 cycle:
  - fc_vec elements = 1..9; fc_clr and fc_enable each pulse exactly once;
  - res_data=45, res_err=0, res_valid at T+4.
- Short frame −3, 7, 2 with in_last on the 3rd word → fc_vec[3..8]=0, res_data=6.
- 10 words with no in_last (values 1..10):
  - frame_err pulses once; first result=45;
  - word 10 starts the next frame (buf[0]=10, rest 0 if in_last on it); second result=10.
- FC model never asserts done → after TIMEOUT=16 WAIT cycles: res_valid=1, res_err=1, res_data=0; next frame then proceeds normally.
- res_ready held low 5 cycles in OUT:
  - res_data stable, res_valid=1, in_ready=0 throughout;
  - in_valid words offered are not accepted until FILL re-entry.
- rst asserted for 1 cycle during WAIT and during OUT:
  - all outputs return to reset values next cycle, no result emitted;
  - a following frame 1..9 yields 45 (FC accumulator was cleared via fc_clr).
